fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit.
- Keeps an internal shift-register scoreboard of in-flight destination registers for the DEPTH stages after ID.
- Resolves all operand bypassing at ID for NUM_SRC source operands, including producers whose results arrive in different stages (ALU vs load).
- Raises a load-use stall itself, inserts the bubble into its own scoreboard, and counts stall cycles.

Parameters:
- NUM_SRC, 2, number of ID-stage source operands checked.
- DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB); minimum 2.
- REG_AW, 5, register address width.
- SEL_W, $clog2(DEPTH+1), width of one forward select and of id_avail_stage.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rd  input  REG_AW  ID destination register
- id_reg_write  input  1  ID instruction writes id_rd
- id_avail_stage  input  SEL_W  first stage index whose output carries the result (ALU=1, load=2)
- id_rs  input  NUM_SRC*REG_AW  source addresses; operand i is bits [i*REG_AW +: REG_AW]
- id_rs_used  input  NUM_SRC  operand i is actually read
- flush  input  1  ID instruction is squashed (taken branch/jump)
- hold  input  1  whole pipeline frozen this cycle (memory wait)
- fwd_sel  output  NUM_SRC*SEL_W  per operand: 0=register file, k=forward from stage k output
- stall  output  1  hold PC and IF/ID, insert bubble into EX
- stall_cycles  output  32  saturating count of cycles with stall=1 and hold=0

Behaviour:
- Scoreboard: DEPTH entries {valid, rd, avail}, entry k = instruction currently in stage k. Only entries with reg_write=1 and rd!=0 are written as valid; all others are written as bubbles (valid=0).
- Avail normalisation: id_avail_stage of 0 or greater than DEPTH is treated as DEPTH.
- Combinational lookup, independently for each operand i, with zero-cycle latency from inputs and entries:
  - Match condition: id_rs_used[i] && id_rs[i]!=0 && entry k valid && entry.rd==id_rs[i].
  - The youngest match (smallest k) wins.
  - fwd_sel[i] = k of the winner, or 0 if there is no match.
  - Operand i hazard = winner exists && k < winner.avail.
- stall = id_valid && !flush && (OR of all operand hazards). stall is not gated by hold.
- fwd_sel is driven as computed even while stall=1. Downstream ignores it during stall.
- Sequential update at posedge clk, in priority order:
  - reset: all entries invalid, stall_cycles=0.
  - hold: entries unchanged, counter unchanged.
  - otherwise, entry k+1 <= entry k for k=1..DEPTH-1, and entry DEPTH is discarded (it has retired to the register file).
  - Entry 1 <= bubble if stall, flush or !id_valid. Otherwise entry 1 <= {id_reg_write && id_rd!=0, id_rd, normalised avail}.
  - stall_cycles increments when stall && !hold, and saturates at 32'hFFFF_FFFF.
- Reset values: all entries invalid, hence fwd_sel=0 and stall=0 one cycle after reset; stall_cycles=0.
- Reset asserted mid-stall: the next cycle shows an empty scoreboard, stall=0 and count=0.
- A stall lasts exactly (winner.avail - k) non-hold cycles, then clears without any external action.
- flush and stall in the same cycle: flush wins, so stall=0, a bubble is inserted and the counter is not incremented.
- WB forwarding (k=DEPTH) is always legal. The register file is not required to be write-before-read.
- One operand may hazard while another forwards; stall is the OR of hazards, and fwd_sel stays per-operand.

Test Plan:
- ALU back-to-back: cycle 0 insert {rd=5, avail=1}; cycle 1 ID reads rs1=5 -> fwd_sel[0]=1, stall=0.
- Load-use: insert load {rd=6, avail=2}; next cycle rs2=6 -> stall=1 for exactly 1 cycle with stall_cycles 0->1; the following cycle fwd_sel[1]=2, stall=0.
- Youngest wins and x0: entries rd=7 at stages 1 and 3 with rs1=7 -> fwd_sel[0]=1; writer rd=0 then rs1=0 -> fwd_sel[0]=0, stall=0.
- Hold during load-use: hold=1 for 3 cycles with the hazard present -> entries frozen, stall stays 1, stall_cycles unchanged; after hold drops, 1 stall cycle, then fwd_sel=2.
- Flush: flush=1 together with id_valid, rd=9 -> next cycle rs1=9 gives fwd_sel[0]=0; flush coinciding with a hazard gives stall=0.
- Reset mid-operation: reset during a load-use stall with stall_cycles=4 -> next cycle stall=0, all fwd_sel=0, stall_cycles=0; also check saturation by preloading the counter to 32'hFFFF_FFFF and stalling once -> value is unchanged.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: ID-stage operand bypass and load-use stall unit with its own in-flight destination scoreboard.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_rd/id_reg_write  ID destination register and its write enable
//   id_avail_stage      first stage whose output carries the result (0 or >DEPTH means DEPTH)
//   id_rs/id_rs_used    packed source addresses and per-operand read flags
//   flush, hold         squash the ID instruction / freeze the whole pipeline
//   fwd_sel             per operand: 0 = register file, k = forward from stage k
//   stall               hold PC and IF/ID, insert a bubble into EX
//   stall_cycles        saturating count of non-hold stall cycles
module fwd_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int REG_AW  = 5,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_write,
    input  logic [SEL_W-1:0]          id_avail_stage,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic                      flush,
    input  logic                      hold,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [31:0]               stall_cycles
);
    logic [DEPTH:1]                   v_q;
    logic [DEPTH:1][REG_AW-1:0]       rd_q;
    logic [DEPTH:1][SEL_W-1:0]        av_q;
    logic [NUM_SRC-1:0]               hz;
    logic [SEL_W-1:0]                 av_n;

    assign av_n = (id_avail_stage == '0 || id_avail_stage > SEL_W'(DEPTH)) ? SEL_W'(DEPTH) : id_avail_stage;

    // Scan oldest to youngest so the youngest match is written last and wins.
    always_comb begin
        fwd_sel = '0;
        hz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (id_rs_used[i] && id_rs[i*REG_AW +: REG_AW] != '0 && v_q[k] && rd_q[k] == id_rs[i*REG_AW +: REG_AW]) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                    hz[i] = SEL_W'(k) < av_q[k];
                end
            end
        end
    end

    assign stall = id_valid && !flush && |hz;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            stall_cycles <= '0;
        end else if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                v_q[k] <= v_q[k-1];
                rd_q[k] <= rd_q[k-1];
                av_q[k] <= av_q[k-1];
            end
            v_q[1] <= id_valid && !stall && !flush && id_reg_write && id_rd != '0;
            rd_q[1] <= id_rd;
            av_q[1] <= av_n;
            if (stall && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed self-checking bench for fwd_scoreboard (NUM_SRC=2, DEPTH=3).
module tb_fwd_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic [1:0]  id_avail_stage;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic        flush;
    logic        hold;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [31:0] stall_cycles;
    int          checks = 0;
    int          failures = 0;

    fwd_scoreboard dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_avail_stage(id_avail_stage),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .flush(flush), .hold(hold),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] av,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                         input logic fl, input logic hd);
        id_valid = v; id_rd = rd; id_reg_write = rw; id_avail_stage = av;
        id_rs = {rs1, rs0}; id_rs_used = used; flush = fl; hold = hd;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_fwd", 32'(fwd_sel), 0);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_cnt", stall_cycles, 0);

        drive(1, 5, 1, 1, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 0, 0, 1, 5, 0, 2'b01, 0, 0);
        chk("alu_fwd", 32'(fwd_sel), 4'h1);
        chk("alu_stall", 32'(stall), 0);
        cyc();

        drive(1, 6, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 0, 0, 1, 0, 6, 2'b10, 0, 0);
        chk("lu_stall", 32'(stall), 1);
        chk("lu_fwd_during", 32'(fwd_sel), 4'h4);
        chk("lu_cnt0", stall_cycles, 0);
        cyc();
        chk("lu_cnt1", stall_cycles, 1);
        chk("lu_fwd_after", 32'(fwd_sel), 4'h8);
        chk("lu_stall_clear", 32'(stall), 0);
        cyc();

        drive(1, 7, 1, 1, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 8, 1, 1, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 7, 1, 1, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 0, 0, 1, 7, 8, 2'b11, 0, 0);
        chk("young_fwd", 32'(fwd_sel), 4'h9);
        chk("young_stall", 32'(stall), 0);
        drive(1, 0, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 0, 0, 1, 0, 0, 2'b11, 0, 0);
        chk("x0_fwd", 32'(fwd_sel), 0);
        chk("x0_stall", 32'(stall), 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0); cyc();

        drive(1, 6, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 0, 0, 1, 0, 6, 2'b10, 0, 1);
        for (int n = 0; n < 3; n++) begin
            chk("hold_stall", 32'(stall), 1);
            chk("hold_fwd", 32'(fwd_sel), 4'h4);
            chk("hold_cnt", stall_cycles, 1);
            cyc();
        end
        drive(1, 0, 0, 1, 0, 6, 2'b10, 0, 0);
        chk("hold_release_stall", 32'(stall), 1);
        cyc();
        chk("hold_cnt2", stall_cycles, 2);
        chk("hold_fwd_after", 32'(fwd_sel), 4'h8);
        chk("hold_stall_clear", 32'(stall), 0);
        cyc();

        drive(1, 9, 1, 1, 0, 0, 2'b00, 1, 0); cyc();
        drive(1, 0, 0, 1, 9, 0, 2'b01, 0, 0);
        chk("flush_bubble_fwd", 32'(fwd_sel), 0);
        chk("flush_bubble_stall", 32'(stall), 0);
        cyc();
        drive(1, 10, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 0, 0, 1, 10, 0, 2'b01, 1, 0);
        chk("flush_hz_stall", 32'(stall), 0);
        chk("flush_hz_fwd", 32'(fwd_sel), 4'h1);
        cyc();
        drive(1, 0, 0, 1, 10, 0, 2'b01, 0, 0);
        chk("flush_hz_cnt", stall_cycles, 2);
        chk("flush_hz_fwd2", 32'(fwd_sel), 4'h2);
        chk("flush_hz_stall2", 32'(stall), 0);
        cyc();

        drive(1, 11, 1, 0, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 0, 0, 1, 11, 0, 2'b01, 0, 0);
        chk("norm_fwd1", 32'(fwd_sel), 4'h1);
        chk("norm_stall1", 32'(stall), 1);
        cyc();
        chk("norm_fwd2", 32'(fwd_sel), 4'h2);
        chk("norm_stall2", 32'(stall), 1);
        cyc();
        chk("norm_fwd3", 32'(fwd_sel), 4'h3);
        chk("norm_stall3", 32'(stall), 0);
        chk("norm_cnt", stall_cycles, 4);
        cyc();

        drive(1, 12, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 0, 0, 1, 12, 0, 2'b01, 0, 0);
        chk("rst_mid_stall_pre", 32'(stall), 1);
        chk("rst_mid_cnt_pre", stall_cycles, 4);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall), 0);
        chk("rst_mid_fwd", 32'(fwd_sel), 0);
        chk("rst_mid_cnt", stall_cycles, 0);
        cyc();

        drive(1, 13, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
        drive(1, 0, 0, 1, 13, 0, 2'b01, 0, 0);
        chk("sat_stall", 32'(stall), 1);
        force dut.stall_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles;
        #1;
        chk("sat_preload", stall_cycles, 32'hFFFF_FFFF);
        cyc();
        chk("sat_cnt", stall_cycles, 32'hFFFF_FFFF);
        chk("sat_fwd", 32'(fwd_sel), 4'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
